// File: rtl/pixel_stream_framer_pkg.sv
// Shared definitions for the pixel stream framer: FSM states, default widths and the
// bit offsets of the frame flags stored above the pixel field in each FIFO entry.
package pixel_stream_framer_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DIM_W_DEF  = 12;

   // Flag positions relative to DATA_W: entry = {sof, eol, eof, data}
   localparam int unsigned EOF_BIT = 0;
   localparam int unsigned EOL_BIT = 1;
   localparam int unsigned SOF_BIT = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_e;

endpackage

// File: rtl/pixel_stream_framer_fifo.sv
// Single-clock FIFO used as the skid buffer of the framer; head entry is visible
// whenever not empty, and a write while full is accepted only if a read happens too.
module pix_sync_fifo #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push, pop;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign pop       = rd_en_i & ~empty_o;
   assign push      = wr_en_i & (~full_o | pop);
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/pixel_stream_framer.sv
// Frames the valid-only filter pixel stream into a ready/valid stream with SOF/EOL/EOF
// markers; a skid FIFO absorbs downstream stalls and sticky flags report drops/bad dims.
module pixel_stream_framer
   import pixel_stream_framer_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned DIM_W      = DIM_W_DEF,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sof,
   output logic              m_eol,
   output logic              m_eof,
   output logic              frame_done,
   output logic [15:0]       frame_count,
   input  logic              clear_err,
   output logic              overflow,
   output logic              cfg_err
);

   localparam int unsigned ENT_W = DATA_W + 3;

   state_e             state_q, state_d;
   logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
   logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
   logic [DIM_W-1:0]   cur_w, cur_h, cur_col, cur_row;
   logic               sof, eol, eof;
   logic               stage_vld_q, stage_vld_d;
   logic [ENT_W-1:0]   stage_q, stage_d;
   logic [ENT_W-1:0]   head;
   logic               fifo_full, fifo_empty, pop;
   logic               ovf_set, cfg_set;
   logic               overflow_q, overflow_d, cfg_err_q, cfg_err_d;
   logic [15:0]        frame_count_q, frame_count_d;

   // In IDLE the beat is pixel (0,0) and geometry comes straight from the dim inputs.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      w_d         = w_q;
      h_d         = h_q;
      stage_vld_d = 1'b0;
      stage_d     = stage_q;
      cfg_set     = 1'b0;
      cur_w       = w_q;
      cur_h       = h_q;
      cur_col     = col_q;
      cur_row     = row_q;
      sof         = 1'b0;
      if (state_q == ST_IDLE) begin
         cur_w   = img_width;
         cur_h   = img_height;
         cur_col = '0;
         cur_row = '0;
         sof     = 1'b1;
      end
      eol = (cur_col == cur_w - DIM_W'(1));
      eof = eol & (cur_row == cur_h - DIM_W'(1));
      if (data_valid) begin
         if (state_q == ST_IDLE) begin
            w_d = img_width;
            h_d = img_height;
         end
         if (state_q == ST_IDLE && (img_width == '0 || img_height == '0)) begin
            cfg_set = 1'b1;
         end else begin
            stage_vld_d                = 1'b1;
            stage_d[DATA_W-1:0]        = data_in;
            stage_d[DATA_W + SOF_BIT]  = sof;
            stage_d[DATA_W + EOL_BIT]  = eol;
            stage_d[DATA_W + EOF_BIT]  = eof;
            col_d   = eol ? '0 : cur_col + DIM_W'(1);
            row_d   = eof ? '0 : (eol ? cur_row + DIM_W'(1) : cur_row);
            state_d = eof ? ST_IDLE : ST_ACTIVE;
         end
      end
   end

   pix_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (stage_vld_q),
      .wr_data_i (stage_q),
      .rd_en_i   (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign m_valid    = ~fifo_empty;
   assign pop        = m_valid & m_ready;
   assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
   assign m_sof      = m_valid & head[DATA_W + SOF_BIT];
   assign m_eol      = m_valid & head[DATA_W + EOL_BIT];
   assign m_eof      = m_valid & head[DATA_W + EOF_BIT];
   assign frame_done = pop & head[DATA_W + EOF_BIT];

   // Geometry has already advanced for a dropped beat, so only the flag records the loss.
   assign ovf_set       = stage_vld_q & fifo_full & ~pop;
   assign overflow_d    = ovf_set | (overflow_q & ~clear_err);
   assign cfg_err_d     = cfg_set | (cfg_err_q & ~clear_err);
   assign frame_count_d = frame_done ? frame_count_q + 16'd1 : frame_count_q;

   assign overflow    = overflow_q;
   assign cfg_err     = cfg_err_q;
   assign frame_count = frame_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         col_q         <= '0;
         row_q         <= '0;
         w_q           <= '0;
         h_q           <= '0;
         stage_vld_q   <= 1'b0;
         stage_q       <= '0;
         overflow_q    <= 1'b0;
         cfg_err_q     <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         row_q         <= row_d;
         w_q           <= w_d;
         h_q           <= h_d;
         stage_vld_q   <= stage_vld_d;
         stage_q       <= stage_d;
         overflow_q    <= overflow_d;
         cfg_err_q     <= cfg_err_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Bench for pixel_stream_framer: directed scenarios plus random traffic, each cycle
// compared against a pixel-index/queue reference model of the framing rules.
module tb_pixel_stream_framer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  data_in;
   logic        data_valid;
   logic [11:0] img_width, img_height;
   logic [7:0]  m_data;
   logic        m_valid, m_ready, m_sof, m_eol, m_eof;
   logic        frame_done;
   logic [15:0] frame_count;
   logic        clear_err, overflow, cfg_err;

   pixel_stream_framer #(
      .DATA_W     (8),
      .DIM_W      (12),
      .FIFO_DEPTH (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .img_width   (img_width),
      .img_height  (img_height),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_sof       (m_sof),
      .m_eol       (m_eol),
      .m_eof       (m_eof),
      .frame_done  (frame_done),
      .frame_count (frame_count),
      .clear_err   (clear_err),
      .overflow    (overflow),
      .cfg_err     (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int hs_cnt = 0;

   // Reference model: entries are {sof,eol,eof,data}; geometry from a flat pixel index.
   logic [10:0] q[$];
   logic        pend_vld;
   logic [10:0] pend;
   bit          in_frame;
   int          mw, mh, p;
   logic        m_ovf, m_cfg;
   logic [15:0] m_fc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      pend_vld = 1'b0;
      pend     = '0;
      in_frame = 1'b0;
      mw = 0; mh = 0; p = 0;
      m_ovf = 1'b0;
      m_cfg = 1'b0;
      m_fc  = '0;
   endfunction

   function automatic void model_update(input logic dv, input logic [7:0] d,
                                        input logic [11:0] w, input logic [11:0] h,
                                        input logic rdy, input logic clr);
      logic pop_now, ovs, cs;
      int   col;
      logic s, el, ef;
      pop_now = rdy && (q.size() != 0);
      ovs = 1'b0;
      cs  = 1'b0;
      if (pop_now) begin
         if (q[0][8]) m_fc = m_fc + 16'd1;
         void'(q.pop_front());
      end
      if (pend_vld) begin
         if (q.size() < 16) q.push_back(pend);
         else ovs = 1'b1;
      end
      pend_vld = 1'b0;
      if (dv) begin
         if (!in_frame) begin
            mw = int'(w);
            mh = int'(h);
            if (mw == 0 || mh == 0) cs = 1'b1;
            else begin
               in_frame = 1'b1;
               p = 0;
            end
         end
         if (in_frame) begin
            col = p % mw;
            s   = (p == 0);
            el  = (col == mw - 1);
            ef  = (p == mw * mh - 1);
            pend = {s, el, ef, d};
            pend_vld = 1'b1;
            p++;
            if (ef) in_frame = 1'b0;
         end
      end
      m_ovf = ovs | (m_ovf & ~clr);
      m_cfg = cs  | (m_cfg & ~clr);
   endfunction

   task automatic step(input logic dv, input logic [7:0] d, input logic [11:0] w,
                       input logic [11:0] h, input logic rdy, input logic clr);
      logic        exp_v;
      logic [10:0] hd;
      @(negedge clk);
      data_valid = dv;
      data_in    = d;
      img_width  = w;
      img_height = h;
      m_ready    = rdy;
      clear_err  = clr;
      #1;
      exp_v = (q.size() != 0);
      hd    = exp_v ? q[0] : 11'd0;
      check("m_valid", 32'(m_valid), 32'(exp_v));
      if (exp_v) check("beat", 32'({m_sof, m_eol, m_eof, m_data}), 32'(hd));
      check("frame_done", 32'(frame_done), 32'(exp_v & rdy & hd[8]));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("cfg_err", 32'(cfg_err), 32'(m_cfg));
      check("frame_count", 32'(frame_count), 32'(m_fc));
      if (m_valid && m_ready) hs_cnt++;
      model_update(dv, d, w, h, rdy, clr);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_data"}, 32'({m_sof, m_eol, m_eof, m_data}), 32'd0);
      check({tag, "_done"}, 32'(frame_done), 32'd0);
      check({tag, "_count"}, 32'(frame_count), 32'd0);
      check({tag, "_err"}, 32'({overflow, cfg_err}), 32'd0);
   endtask

   initial begin
      int base;
      logic [11:0] rw, rh;
      rst_n = 1'b0;
      data_in = '0; data_valid = 1'b0; img_width = '0; img_height = '0;
      m_ready = 1'b0; clear_err = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 4x3 frame, data 1..12, downstream always ready
      for (int i = 0; i < 12; i++) step(1'b1, 8'(i + 1), 12'd4, 12'd3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)  step(1'b0, 8'd0, 12'd4, 12'd3, 1'b1, 1'b0);
      check("frames_4x3", 32'(frame_count), 32'd1);

      // 640-wide line with downstream stalled: 16 kept, rest dropped
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 12'd640, 12'd2, 1'b0, 1'b0);
      step(1'b0, 8'd0, 12'd640, 12'd2, 1'b0, 1'b0);
      base = hs_cnt;
      for (int i = 0; i < 24; i++) step(1'b0, 8'd0, 12'd640, 12'd2, 1'b1, 1'b0);
      check("drain16", 32'(hs_cnt - base), 32'd16);
      for (int i = 20; i < 1280; i++) step(1'b1, 8'($urandom), 12'd7, 12'd7, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 12'd0, 12'd0, 1'b1, i == 0);

      // Fill the FIFO, then push and pop together while full
      for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 12'd4, 12'd8, 1'b0, 1'b0);
      for (int i = 17; i < 32; i++) step(1'b1, 8'($urandom), 12'd4, 12'd8, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, 8'd0, 12'd4, 12'd8, 1'b1, 1'b0);
      check("no_drop_full", 32'(overflow), 32'd0);

      // Zero width: beats rejected, error sticky until cleared, then a valid frame
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 12'd0, 12'd3, 1'b1, 1'b0);
      step(1'b0, 8'd0, 12'd0, 12'd3, 1'b1, 1'b1);
      step(1'b0, 8'd0, 12'd0, 12'd3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 12'd2, 12'd2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 12'd2, 12'd2, 1'b1, 1'b0);

      // Asynchronous reset mid-frame with beats buffered
      for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 12'd4, 12'd3, 1'b0, 1'b0);
      @(negedge clk);
      data_valid = 1'b0; m_ready = 1'b0; clear_err = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 12'd2, 12'd2, 1'b1, 1'b0);

      // Back-to-back 3x2 then 2x2, dims changed during the first frame
      step(1'b1, 8'd21, 12'd3, 12'd2, 1'b1, 1'b0);
      for (int i = 1; i < 6; i++) step(1'b1, 8'(21 + i), 12'd2, 12'd2, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(31 + i), 12'd2, 12'd2, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 12'd2, 12'd2, 1'b1, 1'b0);
      check("frames_b2b", 32'(frame_count), 32'd3);

      // Random traffic with stalls, bad dims and clears
      for (int i = 0; i < 2000; i++) begin
         rw = ($urandom_range(0, 19) == 0) ? 12'd0 : 12'($urandom_range(1, 5));
         rh = ($urandom_range(0, 19) == 0) ? 12'd0 : 12'($urandom_range(1, 4));
         step($urandom_range(0, 3) != 0, 8'($urandom), rw, rh,
              ((i / 64) % 3 == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
              $urandom_range(0, 49) == 0);
      end
      for (int i = 0; i < 24; i++) step(1'b0, 8'd0, 12'd1, 12'd1, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
